// File: rtl/lod_encode_pipe_if.sv
// Handshake bundle for the leading-one encoder pipeline.
// The master side is the producer/consumer pair around the block; the slave side is the encoder itself.
interface lod_encode_pipe_if #(
    parameter int WIDTH = 16
);
    localparam int PW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_lsb;
    logic             out_valid;
    logic             out_ready;
    logic [PW-1:0]    out_pos;
    logic [WIDTH-2:0] out_frac;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_lsb, out_ready,
        input  in_ready, out_valid, out_pos, out_frac, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_lsb, out_ready,
        output in_ready, out_valid, out_pos, out_frac, out_zero
    );
endinterface

// File: rtl/lod_encode_pipe.sv
// Pipelined leading/trailing-one encoder for the logarithmic multiplier datapath.
// Returns the index of the selected one bit and, in leading mode, the MSB-aligned
// bits below it (the Mitchell log mantissa). The encode logic is combinational in
// front of stage 0; LATENCY register stages follow, each with its own valid bit and
// a ready chain so the pipe sustains one result per clock and stalls without loss.
module lod_encode_pipe #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    lod_encode_pipe_if.slave bus
);
    localparam int            PW      = $clog2(WIDTH);
    localparam logic [PW-1:0] TOP_POS = PW'(WIDTH - 1);

    // Encoder results for the operand currently on the input
    logic [PW-1:0]    enc_lead;
    logic [PW-1:0]    enc_trail;
    logic [PW-1:0]    enc_pos;
    logic [WIDTH-2:0] enc_frac;
    logic             enc_zero;

    // Stage registers
    logic [LATENCY-1:0] vld;
    logic [PW-1:0]      pos_q  [LATENCY];
    logic [WIDTH-2:0]   frac_q [LATENCY];
    logic [LATENCY-1:0] zero_q;

    // Per-stage load sources: stage 0 takes the encoder, stage k takes stage k-1
    logic [LATENCY-1:0] src_vld;
    logic [PW-1:0]      src_pos  [LATENCY];
    logic [WIDTH-2:0]   src_frac [LATENCY];
    logic [LATENCY-1:0] src_zero;

    // rdy[k] means stage k may load this cycle; rdy[LATENCY] is the consumer
    logic [LATENCY:0] rdy;

    // Priority encode in both directions, then pick by mode; a zero operand leaves both at 0
    always_comb begin
        enc_lead  = '0;
        enc_trail = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.in_data[i]) enc_lead = PW'(i);
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (bus.in_data[i]) enc_trail = PW'(i);
        end
        enc_zero = ~|bus.in_data;
        enc_pos  = bus.in_lsb ? enc_trail : enc_lead;
        // Dropping the top data bit before the shift is the same as shifting the
        // full word and discarding the leading one itself.
        enc_frac = bus.in_lsb ? '0 : (bus.in_data[WIDTH-2:0] << (TOP_POS - enc_lead));
    end

    // Ready chain from the consumer back to the input: a stage can load if it is
    // empty or its content is moving on this cycle
    always_comb begin
        rdy          = '0;
        rdy[LATENCY] = bus.out_ready;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            rdy[k] = !vld[k] || rdy[k+1];
        end
    end

    // Route each stage's load source
    always_comb begin
        src_vld     = '0;
        src_zero    = '0;
        for (int k = 0; k < LATENCY; k++) begin
            src_pos[k]  = '0;
            src_frac[k] = '0;
        end
        src_vld[0]  = bus.in_valid;
        src_pos[0]  = enc_pos;
        src_frac[0] = enc_frac;
        src_zero[0] = enc_zero;
        for (int k = 1; k < LATENCY; k++) begin
            src_vld[k]  = vld[k-1];
            src_pos[k]  = pos_q[k-1];
            src_frac[k] = frac_q[k-1];
            src_zero[k] = zero_q[k-1];
        end
    end

    // Stage registers: valid follows upstream whenever the stage loads; payload only
    // moves when it carries a real operand, so bubbles leave old payload in place
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld    <= '0;
            zero_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                pos_q[k]  <= '0;
                frac_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                if (rdy[k]) begin
                    vld[k] <= src_vld[k];
                    if (src_vld[k]) begin
                        pos_q[k]  <= src_pos[k];
                        frac_q[k] <= src_frac[k];
                        zero_q[k] <= src_zero[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld[LATENCY-1];
    // Stale payload behind an empty last stage is masked so the outputs read 0
    assign bus.out_pos   = vld[LATENCY-1] ? pos_q[LATENCY-1]  : '0;
    assign bus.out_frac  = vld[LATENCY-1] ? frac_q[LATENCY-1] : '0;
    assign bus.out_zero  = vld[LATENCY-1] & zero_q[LATENCY-1];

endmodule

// File: tb/tb_lod_encode_pipe.sv
// Bench for lod_encode_pipe: directed checks on a 16-bit/2-stage instance and
// randomized handshake runs on 13-bit instances with 1 and 4 stages, scored
// against an arithmetic reference of the encode rules.
module tb_lod_encode_pipe;
    localparam int N_RAND    = 10000;
    localparam int RAND_BUDG = 45000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    lod_encode_pipe_if #(.WIDTH(16)) if_a ();
    lod_encode_pipe_if #(.WIDTH(13)) if_b ();
    lod_encode_pipe_if #(.WIDTH(13)) if_c ();

    lod_encode_pipe #(.WIDTH(16), .LATENCY(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    lod_encode_pipe #(.WIDTH(13), .LATENCY(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    lod_encode_pipe #(.WIDTH(13), .LATENCY(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    // Indexed views of the two 13-bit instances so one random task drives either
    logic [1:0]       r_iv;
    logic [1:0][12:0] r_id;
    logic [1:0]       r_il;
    logic [1:0]       r_or;
    wire  [1:0]       r_ov, r_ir, r_oz;
    wire  [1:0][3:0]  r_op;
    wire  [1:0][11:0] r_of;

    assign if_b.in_valid  = r_iv[0];
    assign if_b.in_data   = r_id[0];
    assign if_b.in_lsb    = r_il[0];
    assign if_b.out_ready = r_or[0];
    assign if_c.in_valid  = r_iv[1];
    assign if_c.in_data   = r_id[1];
    assign if_c.in_lsb    = r_il[1];
    assign if_c.out_ready = r_or[1];
    assign r_ov = {if_c.out_valid, if_b.out_valid};
    assign r_ir = {if_c.in_ready,  if_b.in_ready};
    assign r_oz = {if_c.out_zero,  if_b.out_zero};
    assign r_op = {if_c.out_pos,   if_b.out_pos};
    assign r_of = {if_c.out_frac,  if_b.out_frac};

    logic [63:0] exp_mem [0:N_RAND-1];
    int          acc_cyc [0:N_RAND-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic z, input logic [7:0] p, input logic [31:0] f);
        return (64'(z) << 48) | (64'(p) << 32) | 64'(f);
    endfunction

    // Reference: position from repeated halving / magnitude, mantissa as a
    // modular multiply by the power of two that puts the leading one on top
    function automatic logic [63:0] ref_enc(input logic [63:0] d, input int w, input bit lsb);
        longint unsigned v;
        longint unsigned frac;
        int pos;
        v    = d;
        pos  = 0;
        frac = 0;
        if (v == 0) return pack(1'b1, 8'd0, 32'd0);
        if (lsb) begin
            while (v % 2 == 0) begin
                v = v / 2;
                pos++;
            end
        end else begin
            while ((v >> (pos + 1)) != 0) pos++;
            frac = (v * (64'd1 << (w - 1 - pos))) % (64'd1 << (w - 1));
        end
        return pack(1'b0, 8'(pos), 32'(frac));
    endfunction

    function automatic logic [63:0] got_a();
        return pack(if_a.out_zero, 8'(if_a.out_pos), 32'(if_a.out_frac));
    endfunction

    function automatic logic [63:0] got_r(input int k);
        return pack(r_oz[k], 8'(r_op[k]), 32'(r_of[k]));
    endfunction

    task automatic run_rand(input int k, input int lat);
        int sent, recv, cyc, t;
        bit stalled;
        logic [63:0] held, got, want;
        sent = 0; recv = 0; cyc = 0; stalled = 0; held = '0;
        // single-operand latency probe with the consumer always ready
        @(posedge clk); #1;
        r_iv[k] = 1'b1; r_id[k] = 13'h0155; r_il[k] = 1'b0; r_or[k] = 1'b1;
        @(negedge clk);
        chk("probe_accept", 64'(r_ir[k]), 64'd1);
        @(posedge clk); #1;
        r_iv[k] = 1'b0;
        t = 1;
        @(negedge clk);
        while (!r_ov[k] && t < 12) begin
            @(negedge clk);
            t++;
        end
        chk("probe_latency", 64'(t), 64'(lat));
        chk("probe_result", got_r(k), ref_enc(64'h0155, 13, 1'b0));
        // random valid/ready traffic
        while (recv < N_RAND && cyc < RAND_BUDG) begin
            @(posedge clk); #1;
            r_iv[k] = (sent < N_RAND) && ($urandom_range(1, 0) == 1);
            r_id[k] = ($urandom_range(7, 0) == 0) ? 13'd0 : 13'($urandom);
            r_il[k] = ($urandom_range(3, 0) == 0);
            r_or[k] = ($urandom_range(1, 0) == 1);
            @(negedge clk);
            got = got_r(k);
            if (stalled) chk("rand_stall_hold", {7'd0, r_ov[k], got[55:0]}, {7'd0, 1'b1, held[55:0]});
            if (!r_ov[k]) begin
                chk("rand_idle_zero", got, 64'd0);
            end else if (r_or[k]) begin
                want = (recv < sent) ? exp_mem[recv] : '1;
                chk("rand_result", got, want);
                if (recv < sent)
                    chk("rand_min_latency", 64'(cyc - acc_cyc[recv] >= lat), 64'd1);
                recv++;
            end
            stalled = r_ov[k] && !r_or[k];
            held    = got;
            if (r_iv[k] && r_ir[k]) begin
                exp_mem[sent] = ref_enc(64'(r_id[k]), 13, r_il[k]);
                acc_cyc[sent] = cyc;
                sent++;
            end
            cyc++;
        end
        chk("rand_all_received", 64'(recv), 64'(N_RAND));
        @(posedge clk); #1;
        r_iv[k] = 1'b0;
        r_or[k] = 1'b1;
    endtask

    initial begin
        logic [15:0] sv [5];
        bit          sl [5];
        logic [63:0] se [5];
        logic [15:0] bp_d [4];
        logic [63:0] bp_e [4];
        int sent, recv, cyc, t;

        sv = '{16'h0001, 16'h8000, 16'h00A5, 16'h0000, 16'h00A4};
        sl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        se[0] = pack(1'b0, 8'd0,  32'h0000);
        se[1] = pack(1'b0, 8'd15, 32'h0000);
        se[2] = pack(1'b0, 8'd7,  32'h2500);
        se[3] = pack(1'b1, 8'd0,  32'h0000);
        se[4] = pack(1'b0, 8'd2,  32'h0000);

        r_iv = '0; r_id = '0; r_il = '0; r_or = '1;
        if_a.in_valid  = 1'b1;
        if_a.in_data   = 16'h1234;
        if_a.in_lsb    = 1'b0;
        if_a.out_ready = 1'b1;

        // reset held with a valid operand offered
        repeat (3) begin
            @(negedge clk);
            chk("reset_out_valid", 64'(if_a.out_valid), 64'd0);
            chk("reset_payload", got_a(), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // back-to-back stream with consumer always ready
        for (int c = 0; c < 9; c++) begin
            if (c < 5) begin
                if_a.in_valid = 1'b1;
                if_a.in_data  = sv[c];
                if_a.in_lsb   = sl[c];
            end else begin
                if_a.in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 5) chk("stream_in_ready", 64'(if_a.in_ready), 64'd1);
            chk("stream_out_valid", 64'(if_a.out_valid), 64'(c >= 2 && c < 7));
            if (c >= 2 && c < 7) chk("stream_result", got_a(), se[c-2]);
            @(posedge clk); #1;
        end

        // backpressure: consumer stalls 5 cycles while 4 operands are offered
        for (int i = 0; i < 4; i++) begin
            bp_d[i] = 16'($urandom) | 16'h0100;
            bp_e[i] = ref_enc(64'(bp_d[i]), 16, 1'b0);
        end
        sent = 0; recv = 0; cyc = 0;
        while (recv < 4 && cyc < 40) begin
            if_a.out_ready = (cyc >= 5);
            if_a.in_valid  = (sent < 4);
            if_a.in_data   = (sent < 4) ? bp_d[sent] : 16'h0;
            if_a.in_lsb    = 1'b0;
            @(negedge clk);
            if (cyc < 5) begin
                chk("bp_in_ready", 64'(if_a.in_ready), 64'(sent < 2));
                chk("bp_out_valid", 64'(if_a.out_valid), 64'(cyc >= 2));
                if (if_a.out_valid) chk("bp_hold", got_a(), bp_e[0]);
            end
            if (if_a.out_valid && if_a.out_ready) begin
                chk("bp_result", got_a(), bp_e[recv]);
                recv++;
            end
            if (if_a.in_valid && if_a.in_ready) sent++;
            cyc++;
            @(posedge clk); #1;
        end
        chk("bp_received", 64'(recv), 64'd4);
        if_a.in_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("bp_no_dup", 64'(if_a.out_valid), 64'd0);
            @(posedge clk); #1;
        end

        // reset pulse with operands in flight
        if_a.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if_a.in_valid = 1'b1;
            if_a.in_data  = 16'h0F00 + 16'(i);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(if_a.out_valid), 64'd0);
        @(posedge clk); #1;
        rst_n          = 1'b1;
        if_a.in_valid  = 1'b0;
        if_a.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_stale", 64'(if_a.out_valid), 64'd0);
            @(posedge clk); #1;
        end
        if_a.in_valid = 1'b1;
        if_a.in_data  = 16'h0300;
        if_a.in_lsb   = 1'b0;
        @(negedge clk);
        chk("midrst_accept", 64'(if_a.in_ready), 64'd1);
        @(posedge clk); #1;
        if_a.in_valid = 1'b0;
        t = 1;
        @(negedge clk);
        while (!if_a.out_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("midrst_latency", 64'(t), 64'd2);
        chk("midrst_result", got_a(), pack(1'b0, 8'd9, 32'h4000));

        run_rand(0, 1);
        run_rand(1, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
